// File: rtl/mem_port_arbiter.sv
// Two-client memory port arbiter: icache line refills (fixed-length bursts) and
// single-beat CPU data accesses share one memory port, alternating under contention.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LINE_WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic [DATA_WIDTH-1:0] i_data,
  output logic                  i_valid,
  output logic                  i_done,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  input  logic [3:0]            d_be,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_ack,
  output logic                  m_req,
  output logic                  m_we,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic [DATA_WIDTH-1:0] m_wdata,
  output logic [3:0]            m_be,
  input  logic [DATA_WIDTH-1:0] m_rdata,
  input  logic                  m_ready,
  output logic                  busy
);

  localparam int BEAT_W = $clog2(LINE_WORDS);
  localparam int OFS    = BEAT_W + 2;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_IBURST = 2'd1;
  localparam logic [1:0] S_DACC   = 2'd2;

  localparam logic [BEAT_W-1:0]     LAST_BEAT = BEAT_W'(LINE_WORDS - 1);
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~((ADDR_WIDTH'(1) << OFS) - ADDR_WIDTH'(1));

  logic [1:0]            state_q, state_d;
  logic [BEAT_W-1:0]     beat_q, beat_d;
  logic                  prio_i_q, prio_i_d;  // 1: icache wins the next tie
  logic                  grant_i, grant_d;

  logic [ADDR_WIDTH-1:0] line_base_q;
  logic                  d_we_q;
  logic [ADDR_WIDTH-1:0] d_addr_q;
  logic [DATA_WIDTH-1:0] d_wdata_q;
  logic [3:0]            d_be_q;

  logic                  in_i, in_d;

  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    prio_i_d = prio_i_q;
    grant_i  = 1'b0;
    grant_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_req && (!d_req || prio_i_q)) begin
          grant_i = 1'b1;
          state_d = S_IBURST;
          beat_d  = '0;
        end else if (d_req) begin
          grant_d = 1'b1;
          state_d = S_DACC;
        end
      end
      S_IBURST: begin
        if (m_ready) begin
          // Power-of-two line length lets the counter wrap to 0 on its own.
          beat_d = beat_q + BEAT_W'(1);
          if (beat_q == LAST_BEAT) begin
            state_d  = S_IDLE;
            prio_i_d = 1'b0;
          end
        end
      end
      S_DACC: begin
        if (m_ready) begin
          state_d  = S_IDLE;
          prio_i_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      beat_q   <= '0;
      prio_i_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      prio_i_q <= prio_i_d;
    end
  end

  // Command fields are only observed outside IDLE, so they need no reset.
  always_ff @(posedge clk) begin
    if (grant_i) begin
      line_base_q <= i_addr & LINE_MASK;
    end
    if (grant_d) begin
      d_we_q    <= d_we;
      d_addr_q  <= d_addr;
      d_wdata_q <= d_wdata;
      d_be_q    <= d_be;
    end
  end

  assign in_i = (state_q == S_IBURST);
  assign in_d = (state_q == S_DACC);

  assign busy    = (state_q != S_IDLE);
  assign m_req   = in_i | in_d;
  assign m_we    = in_d & d_we_q;
  assign m_addr  = in_i ? (line_base_q | ADDR_WIDTH'({beat_q, 2'b00})) :
                   in_d ? d_addr_q : '0;
  assign m_wdata = in_d ? d_wdata_q : '0;
  assign m_be    = in_d ? d_be_q : 4'b0000;

  assign i_valid = in_i & m_ready;
  assign i_done  = i_valid & (beat_q == LAST_BEAT);
  assign i_data  = i_valid ? m_rdata : '0;
  assign d_ack   = in_d & m_ready;
  assign d_rdata = d_ack ? m_rdata : '0;

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, address width of all ports.
REQ-002 Parameter DATA_WIDTH, default 32, data width of all ports.
REQ-003 Parameter LINE_WORDS, default 4, icache refill burst length in words; power of two, at least 2.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 i_req  input  1  icache refill request; held high until i_done.
REQ-007 i_addr  input  ADDR_WIDTH  refill address; low log2(LINE_WORDS)+2 bits ignored.
REQ-008 i_data  output  DATA_WIDTH  refill word.
REQ-009 i_valid  output  1  i_data valid this cycle.
REQ-010 i_done  output  1  last refill word this cycle.
REQ-011 d_req  input  1  CPU data access request; held high until d_ack.
REQ-012 d_we  input  1  1 = store, 0 = load.
REQ-013 d_addr  input  ADDR_WIDTH  data address.
REQ-014 d_wdata  input  DATA_WIDTH  store data.
REQ-015 d_be  input  4  store byte enables.
REQ-016 d_rdata  output  DATA_WIDTH  load data.
REQ-017 d_ack  output  1  data access complete this cycle.
REQ-018 m_req  output  1  memory request; held with stable fields until m_ready.
REQ-019 m_we, m_addr, m_wdata, m_be  outputs  1/ADDR_WIDTH/DATA_WIDTH/4  memory command fields.
REQ-020 m_rdata  input  DATA_WIDTH  memory read data; valid when m_ready is high.
REQ-021 m_ready  input  1  current memory beat completes this cycle; any latency of at least 0 cycles.
REQ-022 busy  output  1  high whenever state is not IDLE.

Function
REQ-023 FSM states: IDLE, I_BURST, D_ACC; one transaction owner at a time.
REQ-024 IDLE, only one request high: grant it at the next edge.
REQ-025 IDLE, both requests high: grant the side indicated by prio; prio resets to data.
REQ-026 At grant: latch line base {i_addr[AW-1:log2(LW)+2], 0}, or latch d_we, d_addr, d_wdata and d_be; later input changes are ignored until completion.
REQ-027 I_BURST: m_req=1, m_we=0, m_be=0, m_addr = line base + 4*beat; beat counter starts at 0.
REQ-028 I_BURST with m_ready: i_data=m_rdata and i_valid=1, combinationally in the same cycle; beat increments.
REQ-029 Beat LINE_WORDS-1 with m_ready: i_done=1 in the same cycle; beat wraps to 0, state goes to IDLE, prio goes to data.
REQ-030 D_ACC: m_req=1 with the latched fields.
REQ-031 D_ACC with m_ready: d_ack=1 and d_rdata=m_rdata (m_rdata is don't-care on stores); state goes to IDLE, prio goes to icache.
REQ-032 m_ready while in IDLE is ignored; i_valid, i_done and d_ack stay 0.
REQ-033 Deassertion of a request mid-transaction does not abort it; the burst or access runs to completion.
REQ-034 There is exactly one IDLE cycle between consecutive grants; no combinational path runs from i_req or d_req to m_req.
REQ-035 While m_req=1 and m_ready=0, all m_* fields hold their values.
REQ-036 In IDLE, m_req=0 and m_we=0; m_addr, m_wdata and m_be are 0.

Reset
REQ-037 rst low immediately forces state IDLE, beat 0, prio data, and all outputs 0, independent of clk.
REQ-038 Reset asserted mid-burst or mid-access abandons it with no i_done or d_ack; on reset release, arbitration restarts from IDLE.

Verification
REQ-039 i_req, i_addr=0x0000_1234, m_ready always 1 -> m_addr 0x1230, 0x1234, 0x1238, 0x123C on consecutive cycles; i_valid for 4 cycles; i_done on the 4th; busy for 4 cycles.
REQ-040 d_req store, d_addr=0x1000_0010, d_wdata=0xDEADBEEF, d_be=4'b0011, m_ready delayed 3 cycles -> m_* held stable 3 cycles; d_ack one cycle, on the m_ready cycle.
REQ-041 i_req and d_req rise together from reset -> data served first, one IDLE cycle, then a 4-beat burst; with both held high, grants alternate D, I, D, I.
REQ-042 d_addr changed and d_req dropped after grant, m_ready 2 cycles later -> m_addr equals the original address; d_ack still pulses.
REQ-043 rst low during beat 2 of a burst -> m_req=0 and busy=0 immediately, no i_done; after release, i_req -> burst restarts at beat 0.
REQ-044 m_ready pulsed while IDLE with no requests -> no i_valid, i_done or d_ack; state stays IDLE.
